// File: rtl/ps2_key_ascii_if.sv
// Event/character bus between the keyboard driver, the ASCII translator and
// the downstream character consumer. The slave modport is the translator side.
interface ps2_key_ascii_if #(
  parameter int p_depth = 8
);
  logic                     i_press;
  logic                     i_release;
  logic [15:0]              i_key;
  logic                     i_emp;
  logic                     o_valid;
  logic [7:0]               o_data;
  logic                     i_ready;
  logic [$clog2(p_depth):0] o_level;
  logic                     o_caps;
  logic                     o_ovf;

  modport master (
    output i_press, i_release, i_key, i_emp, i_ready,
    input  o_valid, o_data, o_level, o_caps, o_ovf
  );

  modport slave (
    input  i_press, i_release, i_key, i_emp, i_ready,
    output o_valid, o_data, o_level, o_caps, o_ovf
  );
endinterface

// File: rtl/ps2_key_ascii.sv
// PS/2 set-2 key event to ASCII translator with modifier tracking and a
// show-ahead character FIFO.
// Build option: define PS2_KEY_ASCII_TYPEMATIC_EN to let typematic repeats
// enqueue characters; by default a held-key register suppresses them.
module ps2_key_ascii #(
  parameter int p_depth = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ps2_key_ascii_if.slave io_bus
);
  localparam int c_ptrW = $clog2(p_depth);
  localparam int c_lvlW = c_ptrW + 1;
  localparam logic [c_lvlW-1:0] c_full = c_lvlW'(p_depth);

  logic              w_accept;
  logic              w_press;
  logic              w_release;
  logic              w_plain;
  logic              w_ext;
  logic [7:0]        w_code;
  logic              w_isShiftL;
  logic              w_isShiftR;
  logic              w_isCtrlL;
  logic              w_isCtrlR;
  logic              w_isCaps;
  logic              w_shift;
  logic              w_ctrl;
  logic              w_repeat;
  logic              w_isLetter;
  logic [4:0]        w_letterIdx;
  logic              w_isDigit;
  logic [7:0]        w_digitChar;
  logic [7:0]        w_symChar;
  logic              w_charValid;
  logic [7:0]        w_char;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic [c_ptrW-1:0] w_rdNext;

  logic              r_shiftL;
  logic              r_shiftR;
  logic              r_ctrlL;
  logic              r_ctrlR;
  logic              r_caps;
  logic              r_capsHeld;
  logic              r_charValid;
  logic [7:0]        r_char;
  logic [7:0]        r_mem [p_depth];
  logic [c_ptrW-1:0] r_wrPtr;
  logic [c_ptrW-1:0] r_rdPtr;
  logic [c_lvlW-1:0] r_level;
  logic [7:0]        r_data;
  logic              r_ovf;

  // A simultaneous press and release is a protocol error and is dropped.
  assign w_accept  = (io_bus.i_press ^ io_bus.i_release) & ~io_bus.i_emp;
  assign w_press   = w_accept & io_bus.i_press;
  assign w_release = w_accept & io_bus.i_release;
  assign w_plain   = (io_bus.i_key[15:8] == 8'h00);
  assign w_ext     = (io_bus.i_key[15:8] == 8'hE0);
  assign w_code    = io_bus.i_key[7:0];

  assign w_isShiftL = w_plain && (w_code == 8'h12);
  assign w_isShiftR = w_plain && (w_code == 8'h59);
  assign w_isCtrlL  = w_plain && (w_code == 8'h14);
  assign w_isCtrlR  = w_ext   && (w_code == 8'h14);
  assign w_isCaps   = w_plain && (w_code == 8'h58);
  assign w_shift    = r_shiftL | r_shiftR;
  assign w_ctrl     = r_ctrlL | r_ctrlR;

  // Modifier levels follow make/break; Caps Lock toggles only on a fresh make.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shiftL   <= 1'b0;
      r_shiftR   <= 1'b0;
      r_ctrlL    <= 1'b0;
      r_ctrlR    <= 1'b0;
      r_caps     <= 1'b0;
      r_capsHeld <= 1'b0;
    end else if (w_press) begin
      if (w_isShiftL) r_shiftL <= 1'b1;
      if (w_isShiftR) r_shiftR <= 1'b1;
      if (w_isCtrlL)  r_ctrlL  <= 1'b1;
      if (w_isCtrlR)  r_ctrlR  <= 1'b1;
      if (w_isCaps) begin
        if (!r_capsHeld) r_caps <= ~r_caps;
        r_capsHeld <= 1'b1;
      end
    end else if (w_release) begin
      if (w_isShiftL) r_shiftL   <= 1'b0;
      if (w_isShiftR) r_shiftR   <= 1'b0;
      if (w_isCtrlL)  r_ctrlL    <= 1'b0;
      if (w_isCtrlR)  r_ctrlR    <= 1'b0;
      if (w_isCaps)   r_capsHeld <= 1'b0;
    end
  end

`ifdef PS2_KEY_ASCII_TYPEMATIC_EN
  assign w_repeat = 1'b0;
`else
  logic [15:0] r_heldKey;

  // Remember the most recent make code until its break, to spot repeats.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_heldKey <= 16'h0000;
    end else if (w_press) begin
      r_heldKey <= io_bus.i_key;
    end else if (w_release && (io_bus.i_key == r_heldKey)) begin
      r_heldKey <= 16'h0000;
    end
  end

  assign w_repeat = (io_bus.i_key == r_heldKey);
`endif

  // Classify the low scancode byte as a letter or a digit-row key.
  always_comb begin
    w_isLetter  = 1'b0;
    w_letterIdx = 5'd0;
    w_isDigit   = 1'b0;
    w_digitChar = 8'h00;
    w_symChar   = 8'h00;
    case (w_code)
      8'h1C: begin w_isLetter = 1'b1; w_letterIdx = 5'd0;  end
      8'h32: begin w_isLetter = 1'b1; w_letterIdx = 5'd1;  end
      8'h21: begin w_isLetter = 1'b1; w_letterIdx = 5'd2;  end
      8'h23: begin w_isLetter = 1'b1; w_letterIdx = 5'd3;  end
      8'h24: begin w_isLetter = 1'b1; w_letterIdx = 5'd4;  end
      8'h2B: begin w_isLetter = 1'b1; w_letterIdx = 5'd5;  end
      8'h34: begin w_isLetter = 1'b1; w_letterIdx = 5'd6;  end
      8'h33: begin w_isLetter = 1'b1; w_letterIdx = 5'd7;  end
      8'h43: begin w_isLetter = 1'b1; w_letterIdx = 5'd8;  end
      8'h3B: begin w_isLetter = 1'b1; w_letterIdx = 5'd9;  end
      8'h42: begin w_isLetter = 1'b1; w_letterIdx = 5'd10; end
      8'h4B: begin w_isLetter = 1'b1; w_letterIdx = 5'd11; end
      8'h3A: begin w_isLetter = 1'b1; w_letterIdx = 5'd12; end
      8'h31: begin w_isLetter = 1'b1; w_letterIdx = 5'd13; end
      8'h44: begin w_isLetter = 1'b1; w_letterIdx = 5'd14; end
      8'h4D: begin w_isLetter = 1'b1; w_letterIdx = 5'd15; end
      8'h15: begin w_isLetter = 1'b1; w_letterIdx = 5'd16; end
      8'h2D: begin w_isLetter = 1'b1; w_letterIdx = 5'd17; end
      8'h1B: begin w_isLetter = 1'b1; w_letterIdx = 5'd18; end
      8'h2C: begin w_isLetter = 1'b1; w_letterIdx = 5'd19; end
      8'h3C: begin w_isLetter = 1'b1; w_letterIdx = 5'd20; end
      8'h2A: begin w_isLetter = 1'b1; w_letterIdx = 5'd21; end
      8'h1D: begin w_isLetter = 1'b1; w_letterIdx = 5'd22; end
      8'h22: begin w_isLetter = 1'b1; w_letterIdx = 5'd23; end
      8'h35: begin w_isLetter = 1'b1; w_letterIdx = 5'd24; end
      8'h1A: begin w_isLetter = 1'b1; w_letterIdx = 5'd25; end
      8'h45: begin w_isDigit = 1'b1; w_digitChar = 8'h30; w_symChar = 8'h29; end
      8'h16: begin w_isDigit = 1'b1; w_digitChar = 8'h31; w_symChar = 8'h21; end
      8'h1E: begin w_isDigit = 1'b1; w_digitChar = 8'h32; w_symChar = 8'h40; end
      8'h26: begin w_isDigit = 1'b1; w_digitChar = 8'h33; w_symChar = 8'h23; end
      8'h25: begin w_isDigit = 1'b1; w_digitChar = 8'h34; w_symChar = 8'h24; end
      8'h2E: begin w_isDigit = 1'b1; w_digitChar = 8'h35; w_symChar = 8'h25; end
      8'h36: begin w_isDigit = 1'b1; w_digitChar = 8'h36; w_symChar = 8'h5E; end
      8'h3D: begin w_isDigit = 1'b1; w_digitChar = 8'h37; w_symChar = 8'h26; end
      8'h3E: begin w_isDigit = 1'b1; w_digitChar = 8'h38; w_symChar = 8'h2A; end
      8'h46: begin w_isDigit = 1'b1; w_digitChar = 8'h39; w_symChar = 8'h28; end
      default: ;
    endcase
  end

  // Build the ASCII character for a fresh make code; Ctrl beats Shift/Caps.
  always_comb begin
    w_charValid = 1'b0;
    w_char      = 8'h00;
    if (w_press && !w_repeat) begin
      if (w_plain) begin
        if (w_isLetter) begin
          w_charValid = 1'b1;
          if (w_ctrl) begin
            w_char = {3'b000, w_letterIdx} + 8'd1;
          end else if (w_shift ^ r_caps) begin
            w_char = 8'h41 + {3'b000, w_letterIdx};
          end else begin
            w_char = 8'h61 + {3'b000, w_letterIdx};
          end
        end else if (w_isDigit) begin
          w_charValid = 1'b1;
          w_char      = w_shift ? w_symChar : w_digitChar;
        end else begin
          case (w_code)
            8'h29: begin w_charValid = 1'b1; w_char = 8'h20; end
            8'h5A: begin w_charValid = 1'b1; w_char = 8'h0D; end
            8'h66: begin w_charValid = 1'b1; w_char = 8'h08; end
            8'h0D: begin w_charValid = 1'b1; w_char = 8'h09; end
            8'h76: begin w_charValid = 1'b1; w_char = 8'h1B; end
            default: ;
          endcase
        end
      end else if (w_ext && (w_code == 8'h5A)) begin
        w_charValid = 1'b1;
        w_char      = 8'h0D;
      end
    end
  end

  // Translation stage register between the decoder and the FIFO write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_charValid <= 1'b0;
      r_char      <= 8'h00;
    end else begin
      r_charValid <= w_charValid;
      r_char      <= w_char;
    end
  end

  assign w_full   = (r_level == c_full);
  assign w_pop    = (r_level != '0) && io_bus.i_ready;
  assign w_push   = r_charValid && (!w_full || w_pop);
  assign w_rdNext = r_rdPtr + c_ptrW'(1);

  // Character storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr] <= r_char;
  end

  // FIFO pointers, occupancy, sticky overflow and the registered head value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_data  <= 8'h00;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + c_ptrW'(1);
      if (w_pop)  r_rdPtr <= w_rdNext;
      if (w_push && !w_pop) begin
        r_level <= r_level + c_lvlW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - c_lvlW'(1);
      end
      if (r_charValid && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_pop) begin
        if (r_level > c_lvlW'(1)) begin
          r_data <= r_mem[w_rdNext];
        end else if (w_push) begin
          r_data <= r_char;
        end
      end else if (w_push && (r_level == '0)) begin
        r_data <= r_char;
      end
    end
  end

  assign io_bus.o_valid = (r_level != '0);
  assign io_bus.o_data  = r_data;
  assign io_bus.o_level = r_level;
  assign io_bus.o_caps  = r_caps;
  assign io_bus.o_ovf   = r_ovf;
endmodule
